// File: rtl/scramble_input_pkg.sv
// scramble_input_pkg: scancodes, joystick/output bit positions, coin FSM states and the key-match and port-packing helpers
package scramble_input_pkg;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_t;
  localparam int K_U1 = 0, K_D1 = 1, K_L1 = 2, K_R1 = 3, K_F1 = 4, K_B1 = 5, K_S1 = 6;
  localparam int K_U2 = 7, K_D2 = 8, K_L2 = 9, K_R2 = 10, K_F2 = 11, K_B2 = 12, K_S2 = 13;
  localparam int K_COIN = 14, NKEY = 15;
  localparam int J_R = 0, J_L = 1, J_D = 2, J_U = 3, J_FIRE = 4, J_BOMB = 5, J_S1 = 6, J_S2 = 7, J_COIN = 8;
  localparam int IP_DOWN = 0, IP_UP = 1, IP_RIGHT = 2, IP_LEFT = 3, IP_FIRE = 4, IP_BOMB = 5, IP_START = 6;
  localparam logic [7:0] SC_UP = 8'h75, SC_DN = 8'h72, SC_LF = 8'h6B, SC_RT = 8'h74;
  localparam logic [8:0] SC_B1 = 9'h029, SC_F1 = 9'h014, SC_S1A = 9'h005, SC_S1B = 9'h016;
  localparam logic [8:0] SC_S2A = 9'h006, SC_S2B = 9'h01E, SC_COA = 9'h02E, SC_COB = 9'h036;
  localparam logic [8:0] SC_U2 = 9'h02D, SC_D2 = 9'h02B, SC_L2 = 9'h023, SC_R2 = 9'h034;
  localparam logic [8:0] SC_F2 = 9'h01C, SC_B2 = 9'h01B;
  // Arrows match with or without the E0 prefix, so only the low byte is compared
  function automatic logic [NKEY-1:0] key_hit(input logic [8:0] c);
    logic [NKEY-1:0] v;
    v = '0;
    v[K_U1] = c[7:0] == SC_UP;
    v[K_D1] = c[7:0] == SC_DN;
    v[K_L1] = c[7:0] == SC_LF;
    v[K_R1] = c[7:0] == SC_RT;
    v[K_F1] = c == SC_F1;
    v[K_B1] = c == SC_B1;
    v[K_S1] = c == SC_S1A || c == SC_S1B;
    v[K_U2] = c == SC_U2;
    v[K_D2] = c == SC_D2;
    v[K_L2] = c == SC_L2;
    v[K_R2] = c == SC_R2;
    v[K_F2] = c == SC_F2;
    v[K_B2] = c == SC_B2;
    v[K_S2] = c == SC_S2A || c == SC_S2B;
    v[K_COIN] = c == SC_COA || c == SC_COB;
    return v;
  endfunction
  function automatic logic [6:0] ip_pack(input logic u, d, l, r, f, b, s, rot);
    logic [6:0] v;
    v[IP_UP] = rot ? l : u;
    v[IP_DOWN] = rot ? r : d;
    v[IP_LEFT] = rot ? d : l;
    v[IP_RIGHT] = rot ? u : r;
    v[IP_FIRE] = f;
    v[IP_BOMB] = b;
    v[IP_START] = s;
    return ~v;
  endfunction
endpackage

// File: rtl/scramble_coin_pulser.sv
// scramble_coin_pulser: 1 ms prescaler, saturating coin request queue and pulse/gap FSM
module scramble_coin_pulser
  import scramble_input_pkg::*;
#(
  parameter int CLK_HZ = 24_000_000,
  parameter int PULSE_MS = 100,
  parameter int GAP_MS = 100,
  parameter int QDEPTH = 3
) (
  input  logic clk_sys,
  input  logic RESET_N,
  input  logic req,
  output logic coin
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int PW = $clog2(DIV + 1);
  localparam int QW = $clog2(QDEPTH + 1);
  logic [PW-1:0] pre_q;
  logic [QW-1:0] cnt_q, cnt_d;
  logic [7:0] ms_q, ms_d;
  coin_st_t st_q, st_d;
  logic req_q, tick, deq, enq;
  assign tick = pre_q == PW'(DIV - 1);
  assign coin = st_q == C_PULSE;
  always_comb begin
    deq = st_q == C_IDLE && cnt_q != '0;
    enq = req && !req_q && (cnt_q != QW'(QDEPTH) || deq);
    cnt_d = cnt_q + QW'(enq) - QW'(deq);
    st_d = st_q;
    ms_d = ms_q;
    if (deq) begin
      st_d = C_PULSE;
      ms_d = 8'(PULSE_MS);
    end else if (st_q != C_IDLE && tick) begin
      st_d = ms_q == 8'd1 ? (st_q == C_PULSE ? C_GAP : C_IDLE) : st_q;
      ms_d = ms_q == 8'd1 ? 8'(GAP_MS) : ms_q - 8'd1;
    end
  end
  always_ff @(posedge clk_sys or negedge RESET_N)
    if (!RESET_N) begin
      pre_q <= '0;
      cnt_q <= '0;
      ms_q <= '0;
      st_q <= C_IDLE;
      req_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      cnt_q <= cnt_d;
      ms_q <= ms_d;
      st_q <= st_d;
      req_q <= req;
    end
endmodule

// File: rtl/scramble_input_ctrl.sv
// scramble_input_ctrl: PS/2 keys and MiSTer joysticks to active-low Scramble player ports plus timed coin pulses.
// Define SCRAMBLE_AUTOCOIN_EN to make a start press also post a coin.
module scramble_input_ctrl
  import scramble_input_pkg::*;
#(
  parameter int CLK_HZ = 24_000_000,
  parameter int COIN_PULSE_MS = 100,
  parameter int COIN_GAP_MS = 100,
  parameter int COIN_QDEPTH = 3
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        service,
  output logic [6:0]  ip_1p,
  output logic [6:0]  ip_2p,
  output logic        ip_coin1,
  output logic        ip_coin2,
  output logic        ip_service
);
  logic tog_q, ip_svc_q, coin_req, s1, s2;
  logic [NKEY-1:0] key_q, key_d, hit;
  logic [6:0] ip_1p_q, ip_2p_q, p1_d, p2_d;
  logic [1:0] start_en;
  logic unused_bits;
  assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9], joystick_1[J_S2]};
  // Outputs register the latch next-state so keys and joysticks share the same 1-cycle latency
  always_comb begin
    hit = key_hit(ps2_key[8:0]);
    key_d = ps2_key[10] != tog_q ? (key_q & ~hit) | (hit & {NKEY{ps2_key[9]}}) : key_q;
    s1 = key_d[K_S1] | joystick_0[J_S1];
    s2 = key_d[K_S2] | joystick_1[J_S1] | joystick_0[J_S2];
  end
`ifdef SCRAMBLE_AUTOCOIN_EN
  logic [1:0] st_q, st_rise, hold_q, hold_d;
  logic coin_q;
  // A start press stays masked until the pulse it paid for has finished
  always_comb begin
    st_rise = {s2, s1} & ~st_q;
    hold_d = st_rise | (hold_q & ~{2{coin_q & ~ip_coin1}});
    start_en = ~hold_d;
    coin_req = key_q[K_COIN] | joystick_0[J_COIN] | joystick_1[J_COIN] | |st_rise;
  end
  always_ff @(posedge clk_sys or negedge RESET_N)
    if (!RESET_N) begin
      st_q <= '0;
      hold_q <= '0;
      coin_q <= 1'b0;
    end else begin
      st_q <= {s2, s1};
      hold_q <= hold_d;
      coin_q <= ip_coin1;
    end
`else
  assign start_en = 2'b11;
  assign coin_req = key_q[K_COIN] | joystick_0[J_COIN] | joystick_1[J_COIN];
`endif
  always_comb begin
    p1_d = ip_pack(key_d[K_U1] | joystick_0[J_U], key_d[K_D1] | joystick_0[J_D],
                   key_d[K_L1] | joystick_0[J_L], key_d[K_R1] | joystick_0[J_R],
                   key_d[K_F1] | joystick_0[J_FIRE], key_d[K_B1] | joystick_0[J_BOMB],
                   s1 & start_en[0], rotate);
    p2_d = ip_pack(key_d[K_U2] | joystick_1[J_U], key_d[K_D2] | joystick_1[J_D],
                   key_d[K_L2] | joystick_1[J_L], key_d[K_R2] | joystick_1[J_R],
                   key_d[K_F2] | joystick_1[J_FIRE], key_d[K_B2] | joystick_1[J_BOMB],
                   s2 & start_en[1], rotate);
  end
  always_ff @(posedge clk_sys or negedge RESET_N)
    if (!RESET_N) begin
      tog_q <= 1'b0;
      key_q <= '0;
      ip_1p_q <= 7'h7F;
      ip_2p_q <= 7'h7F;
      ip_svc_q <= 1'b1;
    end else begin
      tog_q <= ps2_key[10];
      key_q <= key_d;
      ip_1p_q <= p1_d;
      ip_2p_q <= p2_d;
      ip_svc_q <= ~service;
    end
  scramble_coin_pulser #(
    .CLK_HZ(CLK_HZ),
    .PULSE_MS(COIN_PULSE_MS),
    .GAP_MS(COIN_GAP_MS),
    .QDEPTH(COIN_QDEPTH)
  ) u_coin (
    .clk_sys(clk_sys),
    .RESET_N(RESET_N),
    .req(coin_req),
    .coin(ip_coin1)
  );
  assign ip_1p = ip_1p_q;
  assign ip_2p = ip_2p_q;
  assign ip_service = ip_svc_q;
  assign ip_coin2 = 1'b0;
endmodule

// File: tb/tb_scramble_input_ctrl.sv
// tb_scramble_input_ctrl: directed stimulus, per-cycle check against a scancode-table model, coin pulse timing monitor
module tb_scramble_input_ctrl;
  logic clk_sys = 0, RESET_N = 0, rotate = 0, service = 0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0, joystick_1 = '0;
  logic [6:0] ip_1p, ip_2p;
  logic ip_coin1, ip_coin2, ip_service;
  int n_chk = 0, n_fail = 0, pulses = 0, base;
  logic tog = 0;
  always #5 clk_sys = ~clk_sys;
  // 4 cycles per ms; pulse 3 ms, gap 2 ms, queue depth 3
  scramble_input_ctrl #(.CLK_HZ(4000), .COIN_PULSE_MS(3), .COIN_GAP_MS(2), .COIN_QDEPTH(3)) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .ps2_key(ps2_key), .joystick_0(joystick_0),
    .joystick_1(joystick_1), .rotate(rotate), .service(service), .ip_1p(ip_1p), .ip_2p(ip_2p),
    .ip_coin1(ip_coin1), .ip_coin2(ip_coin2), .ip_service(ip_service));
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic range_chk(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, v, lo, hi);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask
  task automatic key(input logic [8:0] code, input logic pressed);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
    tick(1);
  endtask
  task automatic coin_tap();
    joystick_0[8] = 1;
    tick(1);
    joystick_0[8] = 0;
    tick(1);
  endtask
  // Model: function numbers 0-6 P1 U,D,L,R,fire,bomb,start; 7-13 same for P2; 14 coin
  typedef struct {logic [8:0] code; bit arrow; int fn;} sc_t;
  sc_t tbl [18] = '{
    '{9'h075, 1, 0}, '{9'h072, 1, 1}, '{9'h06B, 1, 2}, '{9'h074, 1, 3}, '{9'h014, 0, 4},
    '{9'h029, 0, 5}, '{9'h005, 0, 6}, '{9'h016, 0, 6}, '{9'h02D, 0, 7}, '{9'h02B, 0, 8},
    '{9'h023, 0, 9}, '{9'h034, 0, 10}, '{9'h01C, 0, 11}, '{9'h01B, 0, 12}, '{9'h006, 0, 13},
    '{9'h01E, 0, 13}, '{9'h02E, 0, 14}, '{9'h036, 0, 14}};
  bit mk [15];
  bit armed = 0;
  logic mtog = 0, esvc = 1;
  logic [6:0] e1 = 7'h7F, e2 = 7'h7F;
  function automatic logic [6:0] pexp(bit u, bit d, bit l, bit r, bit f, bit b, bit s, bit rot);
    bit uu, dd, ll, rr;
    uu = rot ? l : u;
    dd = rot ? r : d;
    ll = rot ? d : l;
    rr = rot ? u : r;
    return ~{s, b, f, ll, rr, uu, dd};
  endfunction
  always @(posedge clk_sys) begin
    armed = 1;
    if (!RESET_N) begin
      foreach (mk[i]) mk[i] = 0;
      mtog = 0;
      e1 = 7'h7F;
      e2 = 7'h7F;
      esvc = 1;
    end else begin
      if (ps2_key[10] !== mtog) begin
        mtog = ps2_key[10];
        foreach (tbl[i])
          if (tbl[i].arrow ? tbl[i].code[7:0] == ps2_key[7:0] : tbl[i].code == ps2_key[8:0])
            mk[tbl[i].fn] = ps2_key[9];
      end
      e1 = pexp(mk[0] | joystick_0[3], mk[1] | joystick_0[2], mk[2] | joystick_0[1], mk[3] | joystick_0[0],
                mk[4] | joystick_0[4], mk[5] | joystick_0[5], mk[6] | joystick_0[6], rotate);
      e2 = pexp(mk[7] | joystick_1[3], mk[8] | joystick_1[2], mk[9] | joystick_1[1], mk[10] | joystick_1[0],
                mk[11] | joystick_1[4], mk[12] | joystick_1[5], mk[13] | joystick_1[6] | joystick_0[7], rotate);
      esvc = ~service;
    end
  end
  always @(negedge clk_sys)
    if (armed) begin
      check("model_ip_1p", ip_1p, RESET_N ? e1 : 7'h7F);
      check("model_ip_2p", ip_2p, RESET_N ? e2 : 7'h7F);
      check("model_ip_service", ip_service, RESET_N ? esvc : 1'b1);
      check("model_ip_coin2", ip_coin2, 0);
    end
  // Pulse high time must be 9..12 cycles; low time between pulses at least the 8-cycle gap
  int hi_len = 0, lo_len = 1000;
  logic prev = 0;
  always @(negedge clk_sys)
    if (!RESET_N || !armed) begin
      hi_len = 0;
      lo_len = 1000;
      prev = 0;
    end else begin
      if (ip_coin1 && !prev) begin
        range_chk("coin_gap_cycles", lo_len, 8, 1000000);
        pulses++;
        hi_len = 0;
      end
      if (!ip_coin1 && prev) begin
        range_chk("coin_high_cycles", hi_len, 9, 12);
        lo_len = 0;
      end
      if (ip_coin1) hi_len++;
      else if (lo_len < 1000000) lo_len++;
      prev = ip_coin1;
    end
  initial begin
    tick(3);
    check("reset_ip_1p", ip_1p, 7'h7F);
    check("reset_ip_2p", ip_2p, 7'h7F);
    check("reset_ip_coin1", ip_coin1, 0);
    check("reset_ip_service", ip_service, 1);
    RESET_N = 1;
    tick(2);
    key(9'h175, 1);
    check("key_up_press", ip_1p, 7'h7D);
    key(9'h175, 0);
    check("key_up_release", ip_1p, 7'h7F);
    key(9'h072, 1);
    check("key_down_plain", ip_1p, 7'h7E);
    key(9'h172, 0);
    check("key_down_e0_release", ip_1p, 7'h7F);
    key(9'h0AA, 1);
    check("key_unknown_p1", ip_1p, 7'h7F);
    check("key_unknown_p2", ip_2p, 7'h7F);
    key(9'h01C, 1);
    check("key_p2_fire", ip_2p, 7'h6F);
    key(9'h01C, 0);
    key(9'h016, 1);
    check("key_p1_start", ip_1p, 7'h3F);
    key(9'h016, 0);
    joystick_0 = 16'h0080;
    tick(1);
    check("joy0_start2_to_p2", ip_2p, 7'h3F);
    check("joy0_start2_not_p1", ip_1p, 7'h7F);
    rotate = 1;
    joystick_0 = 16'h0002;
    tick(1);
    check("rot_left_to_up", ip_1p, 7'h7D);
    check("rot_p2_idle", ip_2p, 7'h7F);
    joystick_0 = 0;
    joystick_1 = 16'h0001;
    tick(1);
    check("rot_right_to_down", ip_2p, 7'h7E);
    joystick_1 = 0;
    key(9'h02D, 1);
    check("rot_key_up_to_right", ip_2p, 7'h7B);
    key(9'h02D, 0);
    rotate = 0;
    service = 1;
    tick(1);
    check("service_on", ip_service, 0);
    service = 0;
    tick(2);
    // coin latency: request edge then two edges to PULSE
    base = pulses;
    joystick_0[8] = 1;
    tick(1);
    check("coin_latency_1", ip_coin1, 0);
    tick(1);
    check("coin_latency_2", ip_coin1, 1);
    joystick_0[8] = 0;
    tick(30);
    check("single_coin_count", pulses - base, 1);
    base = pulses;
    coin_tap();
    coin_tap();
    tick(60);
    check("two_coin_count", pulses - base, 2);
    base = pulses;
    coin_tap();
    tick(2);
    repeat (5) coin_tap();
    tick(110);
    check("queue_saturate_count", pulses - base, 4);
    base = pulses;
    key(9'h02E, 1);
    key(9'h02E, 0);
    tick(30);
    check("ps2_coin_count", pulses - base, 1);
    coin_tap();
    coin_tap();
    begin
      int w;
      for (w = 0; w < 20 && !ip_coin1; w++) tick(1);
      check("coin_wait_before_reset", ip_coin1, 1);
    end
    tick(2);
    RESET_N = 0;
    #1;
    check("reset_mid_pulse", ip_coin1, 0);
    tick(2);
    RESET_N = 1;
    base = pulses;
    tick(60);
    check("no_coin_after_reset", pulses - base, 0);
    check("coin_idle_after_reset", ip_coin1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
